pl_tx_sched: RTL and testbench

PL_TX_SCHED -- requirements
Module: pl_tx_sched

---
 rtl/pl_tx_sched_pkg.sv | 40 ++++
 rtl/pl_tx_sched_if.sv | 42 ++++
 rtl/pl_tx_sched_timer.sv | 29 ++
 rtl/pl_tx_sched.sv | 164 ++++++++++++++++
 tb/tb_pl_tx_sched.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pl_tx_sched_pkg.sv
// -----------------------------------------------------------------------------
// pd_pl_pkg : shared definitions for the PD protocol-layer transmit scheduler.
//   tx_state_e  : scheduler FSM states
//   PHY_*       : PHY packet type codes (SOP, SOP', SOP'', hard reset)
//   RES_*       : message completion result codes
//   tx_cpl_t    : one-cycle completion pulses plus held message result
// -----------------------------------------------------------------------------
package pd_pl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_TX_HRST    = 3'd1,
      ST_TX_GOODCRC = 3'd2,
      ST_TX_MSG     = 3'd3,
      ST_WAIT_CRC   = 3'd4
   } tx_state_e;

   localparam logic [2:0] PHY_SOP    = 3'h0;
   localparam logic [2:0] PHY_SOP_P  = 3'h1;
   localparam logic [2:0] PHY_SOP_PP = 3'h2;
   localparam logic [2:0] PHY_HRST   = 3'h3;

   localparam logic [1:0] RES_OK      = 2'h0;
   localparam logic [1:0] RES_DISCARD = 2'h1;
   localparam logic [1:0] RES_NO_CRC  = 2'h2;
   localparam logic [1:0] RES_HRST    = 2'h3;

   typedef struct packed {
      logic       msg_done;
      logic       gcrc_done;
      logic       hrst_done;
      logic [1:0] msg_result;
   } tx_cpl_t;

   // MessageID is a 3-bit rolling counter
   function automatic logic [2:0] next_msg_id(input logic [2:0] id);
      return id + 3'd1;
   endfunction

endpackage

// File: rtl/pl_tx_sched_if.sv
// -----------------------------------------------------------------------------
// pl_tx_sched_if : request / PHY bus of the transmit scheduler.
//   slave  : scheduler side (takes requests and PHY status, drives PHY requests)
//   master : environment side (policy engine + PHY)
// -----------------------------------------------------------------------------
interface pl_tx_sched_if;
   logic       req_hrst_en;
   logic       req_hrst_done;
   logic       req_goodcrc_en;
   logic       req_goodcrc_done;
   logic       req_msg_en;
   logic [2:0] req_msg_type;
   logic       req_msg_done;
   logic [1:0] req_msg_result;
   logic       pl2phy_tx_packet_en;
   logic [2:0] pl2phy_tx_packet_type;
   logic       phy2pl_tx_packet_done;
   logic       phy2pl_tx_packet_result;
   logic       phy2pl_rx_packet_done;
   logic [1:0] phy2pl_rx_packet_result;
   logic       rx_goodcrc_match;
   logic       pl2phy_rx_packet_select;
   logic [2:0] tx_msg_id;

   modport slave (
      input  req_hrst_en, req_goodcrc_en, req_msg_en, req_msg_type,
             phy2pl_tx_packet_done, phy2pl_tx_packet_result,
             phy2pl_rx_packet_done, phy2pl_rx_packet_result, rx_goodcrc_match,
      output req_hrst_done, req_goodcrc_done, req_msg_done, req_msg_result,
             pl2phy_tx_packet_en, pl2phy_tx_packet_type,
             pl2phy_rx_packet_select, tx_msg_id
   );

   modport master (
      output req_hrst_en, req_goodcrc_en, req_msg_en, req_msg_type,
             phy2pl_tx_packet_done, phy2pl_tx_packet_result,
             phy2pl_rx_packet_done, phy2pl_rx_packet_result, rx_goodcrc_match,
      input  req_hrst_done, req_goodcrc_done, req_msg_done, req_msg_result,
             pl2phy_tx_packet_en, pl2phy_tx_packet_type,
             pl2phy_rx_packet_select, tx_msg_id
   );
endinterface

// File: rtl/pl_tx_sched_timer.sv
// -----------------------------------------------------------------------------
// pl_tx_timer : GoodCRC wait timer.
//   clk, rst_n : clock, async active-low reset
//   i_load     : clear count to 0 (wins over i_en)
//   i_en       : count up by one
//   o_expire   : count has reached TIMEOUT-1 (last waiting cycle)
// -----------------------------------------------------------------------------
module pl_tx_timer #(
   parameter int           W       = 16,
   parameter logic [W-1:0] TIMEOUT = 16'd1800
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_load,
   input  logic i_en,
   output logic o_expire
);
   localparam logic [W-1:0] LAST = TIMEOUT - 1'b1;

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      r_cnt <= '0;
      else if (i_load) r_cnt <= '0;
      else if (i_en)   r_cnt <= r_cnt + 1'b1;
   end

   assign o_expire = (r_cnt == LAST);
endmodule

// File: rtl/pl_tx_sched.sv
// -----------------------------------------------------------------------------
// pl_tx_sched : PD protocol-layer transmit scheduler.
//   clk, rst_n : clock, async active-low reset
//   io_if      : pl_tx_sched_if.slave -- hard reset / GoodCRC / message
//                requests with done pulses, PHY tx request/completion,
//                PHY rx completion with GoodCRC match, tx_msg_id.
// Arbitrates requests by fixed priority (hard reset > GoodCRC > message),
// drives one PHY transmit at a time and waits CRC_RX_TIMEOUT cycles for
// the GoodCRC of a transmitted message.
// Build option: define PL_TX_SCHED_RETRY_EN to retransmit a message up to
// N_RETRY times on GoodCRC timeout; otherwise a timeout fails immediately.
// -----------------------------------------------------------------------------
module pl_tx_sched
   import pd_pl_pkg::*;
#(
   parameter logic [15:0] CRC_RX_TIMEOUT = 16'd1800,
   parameter int          N_RETRY        = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   pl_tx_sched_if.slave  io_if
);
`ifdef PL_TX_SCHED_RETRY_EN
   localparam bit RETRY_EN = 1'b1;
`else
   localparam bit RETRY_EN = 1'b0;
`endif
   localparam logic [7:0] RETRY_MAX = 8'(N_RETRY);

   tx_state_e  r_state, w_next;
   tx_cpl_t    r_cpl, w_cpl;
   logic [2:0] r_type, w_type_nxt, r_msg_id;
   logic [7:0] r_retry;
   logic       w_type_ld, w_id_inc, w_id_clr, w_rty_inc, w_rty_clr;
   logic       w_tx_en, w_rx_sel, w_tmr_load, w_tmr_en, w_expire;
   logic       w_match, w_can_retry;

   assign w_match = io_if.phy2pl_rx_packet_done &&
                    (io_if.phy2pl_rx_packet_result == 2'd0) && io_if.rx_goodcrc_match;
   assign w_can_retry = RETRY_EN && (r_retry < RETRY_MAX);

   pl_tx_timer #(.W(16), .TIMEOUT(CRC_RX_TIMEOUT)) u_tmr (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_load   (w_tmr_load),
      .i_en     (w_tmr_en),
      .o_expire (w_expire)
   );

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   // next state; hard reset in WAIT_CRC aborts ahead of match/timeout,
   // and a match beats a timeout landing in the same cycle
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:
            if (io_if.req_hrst_en)         w_next = ST_TX_HRST;
            else if (io_if.req_goodcrc_en) w_next = ST_TX_GOODCRC;
            else if (io_if.req_msg_en)     w_next = ST_TX_MSG;
         ST_TX_HRST, ST_TX_GOODCRC:
            if (io_if.phy2pl_tx_packet_done) w_next = ST_IDLE;
         ST_TX_MSG:
            if (io_if.phy2pl_tx_packet_done)
               w_next = io_if.phy2pl_tx_packet_result ? ST_IDLE : ST_WAIT_CRC;
         ST_WAIT_CRC:
            if (io_if.req_hrst_en)  w_next = ST_TX_HRST;
            else if (w_match)       w_next = ST_IDLE;
            else if (w_expire)      w_next = w_can_retry ? ST_TX_MSG : ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // outputs and datapath controls
   always_comb begin
      w_cpl            = '0;
      w_cpl.msg_result = r_cpl.msg_result;
      w_tx_en    = r_state inside {ST_TX_HRST, ST_TX_GOODCRC, ST_TX_MSG};
      w_rx_sel   = (r_state == ST_WAIT_CRC);
      w_tmr_en   = w_rx_sel;
      w_tmr_load = !w_rx_sel;       // timer sits at 0 until WAIT_CRC is entered
      w_type_ld  = 1'b0;
      w_type_nxt = r_type;
      w_id_inc   = 1'b0;
      w_id_clr   = 1'b0;
      w_rty_inc  = 1'b0;
      w_rty_clr  = 1'b0;
      case (r_state)
         ST_IDLE:
            if (io_if.req_hrst_en) begin
               w_type_ld  = 1'b1;
               w_type_nxt = PHY_HRST;
            end else if (io_if.req_goodcrc_en || io_if.req_msg_en) begin
               w_type_ld  = 1'b1;
               w_type_nxt = io_if.req_msg_type;
            end
         ST_TX_HRST:
            if (io_if.phy2pl_tx_packet_done) begin
               w_cpl.hrst_done = 1'b1;
               w_id_clr        = 1'b1;
               w_rty_clr       = 1'b1;
            end
         ST_TX_GOODCRC:
            if (io_if.phy2pl_tx_packet_done) w_cpl.gcrc_done = 1'b1;
         ST_TX_MSG:
            if (io_if.phy2pl_tx_packet_done && io_if.phy2pl_tx_packet_result) begin
               w_cpl.msg_done   = 1'b1;
               w_cpl.msg_result = RES_DISCARD;
               w_rty_clr        = 1'b1;
            end
         ST_WAIT_CRC:
            if (io_if.req_hrst_en) begin
               w_cpl.msg_done   = 1'b1;
               w_cpl.msg_result = RES_HRST;
               w_type_ld        = 1'b1;
               w_type_nxt       = PHY_HRST;
               w_rty_clr        = 1'b1;
            end else if (w_match) begin
               w_cpl.msg_done   = 1'b1;
               w_cpl.msg_result = RES_OK;
               w_id_inc         = 1'b1;
               w_rty_clr        = 1'b1;
            end else if (w_expire) begin
               if (w_can_retry) begin
                  w_rty_inc = 1'b1;
               end else begin
                  w_cpl.msg_done   = 1'b1;
                  w_cpl.msg_result = RES_NO_CRC;
                  w_rty_clr        = 1'b1;
               end
            end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cpl    <= '0;
         r_type   <= 3'h0;
         r_msg_id <= 3'h0;
         r_retry  <= 8'h0;
      end else begin
         r_cpl <= w_cpl;
         if (w_type_ld) r_type <= w_type_nxt;
         if (w_id_clr)      r_msg_id <= 3'h0;
         else if (w_id_inc) r_msg_id <= next_msg_id(r_msg_id);
         if (w_rty_clr)      r_retry <= 8'h0;
         else if (w_rty_inc) r_retry <= r_retry + 8'd1;
      end
   end

   assign io_if.pl2phy_tx_packet_en     = w_tx_en;
   assign io_if.pl2phy_tx_packet_type   = r_type;
   assign io_if.pl2phy_rx_packet_select = w_rx_sel;
   assign io_if.tx_msg_id               = r_msg_id;
   assign io_if.req_msg_done            = r_cpl.msg_done;
   assign io_if.req_msg_result          = r_cpl.msg_result;
   assign io_if.req_goodcrc_done        = r_cpl.gcrc_done;
   assign io_if.req_hrst_done           = r_cpl.hrst_done;
endmodule

// File: tb/tb_pl_tx_sched.sv
// -----------------------------------------------------------------------------
// tb_pl_tx_sched : randomized scoreboard bench for pl_tx_sched.
// The driver plays policy engine and PHY, pushing expected PHY attempt types
// and expected completions; the monitor pops them when the DUT raises a PHY
// request or pulses a done.
// -----------------------------------------------------------------------------
module tb_pl_tx_sched;
   import pd_pl_pkg::*;

   localparam int T  = 1800;
   localparam int NR = 2;
`ifdef PL_TX_SCHED_RETRY_EN
   localparam int ATTEMPTS = NR + 1;
`else
   localparam int ATTEMPTS = 1;
`endif
   localparam int S_OK = 0, S_DISC = 1, S_TO = 2, S_EDGE = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pl_tx_sched_if bus ();

   pl_tx_sched #(.CRC_RX_TIMEOUT(16'(T)), .N_RETRY(NR)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io_if (bus)
   );

   typedef struct { int kind; int res; int id; } cpl_t;   // kind 0 msg, 1 goodcrc, 2 hrst
   cpl_t exp_q[$];
   int   att_q[$];
   int   n_vec = 0, n_err = 0;
   int   model_id = 0;
   bit   stop = 1'b0;

   task automatic chk(input string nm, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   // reference model: completion order and MessageID bookkeeping
   task automatic exp_msg(input int res);
      cpl_t e;
      if (res == 0) model_id = (model_id + 1) % 8;
      e.kind = 0; e.res = res; e.id = model_id;
      exp_q.push_back(e);
   endtask

   task automatic exp_other(input int kind);
      cpl_t e;
      if (kind == 2) model_id = 0;
      e.kind = kind; e.res = 0; e.id = model_id;
      exp_q.push_back(e);
   endtask

   task automatic wait_en(input string nm, output bit ok);
      int k = 0;
      while (!bus.pl2phy_tx_packet_en && k < T + 50) begin
         @(negedge clk);
         k++;
      end
      ok = bus.pl2phy_tx_packet_en;
      chk(nm, int'(ok), 1);
   endtask

   task automatic phy_done(input bit res);
      chk("en_before_done", int'(bus.pl2phy_tx_packet_en), 1);
      bus.phy2pl_tx_packet_result = res;
      bus.phy2pl_tx_packet_done   = 1'b1;
      @(negedge clk);
      bus.phy2pl_tx_packet_done   = 1'b0;
      bus.phy2pl_tx_packet_result = 1'b0;
      chk("en_after_done", int'(bus.pl2phy_tx_packet_en), 0);
   endtask

   task automatic rx_pulse(input logic [1:0] res, input bit m);
      bus.phy2pl_rx_packet_result = res;
      bus.rx_goodcrc_match        = m;
      bus.phy2pl_rx_packet_done   = 1'b1;
      @(negedge clk);
      bus.phy2pl_rx_packet_done   = 1'b0;
      bus.phy2pl_rx_packet_result = 2'd0;
      bus.rx_goodcrc_match        = 1'b0;
   endtask

   task automatic wait_done(input string nm, input int c0);
      int k = 0;
      while (!bus.req_msg_done && k < T + 50) begin
         @(negedge clk);
         k++;
      end
      chk(nm, cyc - c0, T);
      tick(1);
   endtask

   // d: cycle in WAIT_CRC (1..T) whose closing edge samples the GoodCRC
   task automatic msg_txn(input int scn, input int d, input bit noise);
      bit ok;
      int ty, c0, dd;
      ty = $urandom_range(0, 2);
      bus.req_msg_type = 3'(ty);
      bus.req_msg_en   = 1'b1;
      if (scn == S_TO) begin
         repeat (ATTEMPTS) att_q.push_back(ty);
         exp_msg(2);
      end else begin
         att_q.push_back(ty);
         exp_msg(scn == S_DISC ? 1 : 0);
      end
      wait_en("msg_grant", ok);
      bus.req_msg_en   = 1'b0;
      bus.req_msg_type = 3'($urandom_range(0, 7));   // must not disturb the registered type
      if (!ok) return;
      tick($urandom_range(0, 3));
      phy_done(scn == S_DISC);
      case (scn)
         S_DISC: tick(3);
         S_OK, S_EDGE: begin
            dd = (scn == S_EDGE) ? T : d;
            if (noise && dd >= 3) begin
               rx_pulse(2'd0, 1'b0);
               tick(dd - 2);
            end else begin
               tick(dd - 1);
            end
            rx_pulse(2'd0, 1'b1);
            tick(2);
         end
         default: begin
            for (int a = 0; a < ATTEMPTS; a++) begin
               c0 = cyc;
               if (noise) begin
                  rx_pulse(2'd0, 1'b0);
                  rx_pulse(2'd1, 1'b1);
                  rx_pulse(2'd2, 1'b1);
               end
               if (a < ATTEMPTS - 1) begin
                  wait_en("retry_en", ok);
                  chk("retry_gap", cyc - c0, T);
                  if (!ok) return;
                  tick(1);
                  phy_done(1'b0);
               end else begin
                  wait_done("nocrc_gap", c0);
               end
            end
         end
      endcase
   endtask

   task automatic gcrc_txn();
      bit ok;
      int ty;
      ty = $urandom_range(0, 2);
      bus.req_msg_type   = 3'(ty);
      bus.req_goodcrc_en = 1'b1;
      att_q.push_back(ty);
      exp_other(1);
      wait_en("gcrc_grant", ok);
      bus.req_goodcrc_en = 1'b0;
      if (!ok) return;
      tick($urandom_range(0, 3));
      phy_done(1'($urandom_range(0, 1)));
      tick(2);
   endtask

   task automatic hrst_txn();
      bit ok;
      bus.req_hrst_en = 1'b1;
      att_q.push_back(3);
      exp_other(2);
      wait_en("hrst_grant", ok);
      bus.req_hrst_en = 1'b0;
      if (!ok) return;
      tick($urandom_range(0, 3));
      phy_done(1'b0);
      tick(2);
   endtask

   task automatic dual_txn();
      bit ok;
      int ty;
      ty = $urandom_range(0, 2);
      bus.req_msg_type = 3'(ty);
      bus.req_hrst_en  = 1'b1;
      bus.req_msg_en   = 1'b1;
      att_q.push_back(3);
      att_q.push_back(ty);
      exp_other(2);
      exp_msg(0);
      wait_en("dual_hrst", ok);
      bus.req_hrst_en = 1'b0;
      if (!ok) begin
         bus.req_msg_en = 1'b0;
         return;
      end
      tick(1);
      phy_done(1'b0);
      wait_en("dual_msg", ok);
      bus.req_msg_en = 1'b0;
      if (!ok) return;
      phy_done(1'b0);
      tick(99);
      rx_pulse(2'd0, 1'b1);
      tick(2);
   endtask

   task automatic abort_txn(input int d);
      bit ok;
      int ty;
      ty = $urandom_range(0, 2);
      bus.req_msg_type = 3'(ty);
      bus.req_msg_en   = 1'b1;
      att_q.push_back(ty);
      att_q.push_back(3);
      exp_msg(3);
      exp_other(2);
      wait_en("abort_msg", ok);
      bus.req_msg_en = 1'b0;
      if (!ok) return;
      tick(1);
      phy_done(1'b0);
      tick(d - 1);
      chk("rx_select_wait", int'(bus.pl2phy_rx_packet_select), 1);
      bus.req_hrst_en = 1'b1;
      wait_en("abort_hrst", ok);
      bus.req_hrst_en = 1'b0;
      if (!ok) return;
      tick(2);
      phy_done(1'b0);
      tick(2);
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_en"},     int'(bus.pl2phy_tx_packet_en), 0);
      chk({tag, "_type"},   int'(bus.pl2phy_tx_packet_type), 0);
      chk({tag, "_sel"},    int'(bus.pl2phy_rx_packet_select), 0);
      chk({tag, "_id"},     int'(bus.tx_msg_id), 0);
      chk({tag, "_result"}, int'(bus.req_msg_result), 0);
      chk({tag, "_dones"},  int'({bus.req_msg_done, bus.req_goodcrc_done, bus.req_hrst_done}), 0);
   endtask

   initial begin
      bit ok;
      bus.req_hrst_en = 1'b0;  bus.req_goodcrc_en = 1'b0;
      bus.req_msg_en  = 1'b0;  bus.req_msg_type   = 3'h0;
      bus.phy2pl_tx_packet_done = 1'b0;  bus.phy2pl_tx_packet_result = 1'b0;
      bus.phy2pl_rx_packet_done = 1'b0;  bus.phy2pl_rx_packet_result = 2'd0;
      bus.rx_goodcrc_match      = 1'b0;
      tick(3);
      reset_checks("reset");
      rst_n = 1'b1;
      tick(2);
      fork
         begin : driver
            msg_txn(S_OK, 100, 1'b0);
            msg_txn(S_DISC, 0, 1'b0);
            for (int i = 0; i < 8; i++) msg_txn(S_OK, $urandom_range(1, 20), 1'b1);
            msg_txn(S_TO, 0, 1'b0);
            msg_txn(S_TO, 0, 1'b1);
            msg_txn(S_EDGE, 0, 1'b0);
            dual_txn();
            msg_txn(S_OK, 7, 1'b0);
            abort_txn(50);
            for (int i = 0; i < 20; i++) begin
               case ($urandom_range(0, 3))
                  0:       msg_txn(S_OK, $urandom_range(1, 300), 1'($urandom_range(0, 1)));
                  1:       msg_txn(S_DISC, 0, 1'b0);
                  2:       gcrc_txn();
                  default: hrst_txn();
               endcase
            end
            msg_txn(S_OK, 5, 1'b0);
            // reset in the middle of a message transmit
            bus.req_msg_type = 3'h1;
            bus.req_msg_en   = 1'b1;
            att_q.push_back(1);
            wait_en("rst_msg_grant", ok);
            bus.req_msg_en = 1'b0;
            tick(2);
            #2 rst_n = 1'b0;
            #1 chk("rst_async_en", int'(bus.pl2phy_tx_packet_en), 0);
            model_id = 0;
            tick(2);
            reset_checks("midrst");
            rst_n = 1'b1;
            tick(20);
            msg_txn(S_OK, 3, 1'b0);
            tick(10);
            chk("exp_q_drained", exp_q.size(), 0);
            chk("att_q_drained", att_q.size(), 0);
            stop = 1'b1;
         end
         begin : monitor
            bit   pen;
            int   ak;
            cpl_t e;
            pen = 1'b0;
            while (!stop) begin
               @(negedge clk);
               if (bus.pl2phy_tx_packet_en && !pen) begin
                  chk("attempt_expected", int'(att_q.size() > 0), 1);
                  if (att_q.size() > 0)
                     chk("phy_type", int'(bus.pl2phy_tx_packet_type), att_q.pop_front());
               end
               pen = bus.pl2phy_tx_packet_en;
               if (bus.req_msg_done || bus.req_goodcrc_done || bus.req_hrst_done) begin
                  chk("done_expected", int'(exp_q.size() > 0), 1);
                  if (exp_q.size() > 0) begin
                     e  = exp_q.pop_front();
                     ak = bus.req_msg_done ? 0 : (bus.req_goodcrc_done ? 1 : 2);
                     chk("done_kind", ak, e.kind);
                     if (e.kind == 0) chk("msg_result", int'(bus.req_msg_result), e.res);
                     chk("tx_msg_id", int'(bus.tx_msg_id), e.id);
                  end
               end
            end
         end
      join
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: summary not reached, vectors=%0d", n_vec);
      $fatal(1);
   end
endmodule
